ahb_mtx_out_arb: RTL and testbench

round-robin arbiter for one bus-matrix output stage, shared by input ports S0..S2; it generates the address-phase port select, the data-phase port select and the per-port active feedback.

Interface
REQ-001 Parameter RR_EN, default 1, meaning 1 = round-robin arbitration, 0 = fixed priority with S0 highest and S2 lowest.
REQ-002 HCLK  input  1  system clock; all state changes on rising edge.
REQ-003 HRESET  input  1  asynchronous, active-high reset.
REQ-004 req_sel  input  3  bit n is the output-port select from input port Sn's decoder.
REQ-005 trans_op  input  6  HTRANS of port n at bits [2n+1:2n]; encoding 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-006 lock_op  input  3  bit n is HMASTLOCK of port n.
REQ-007 HREADYM  input  1  HREADY of the output stage (slave-side completion).
REQ-008 addr_in_port  output  2  address-phase owner: 00, 01 or 10; 11 means no port.
REQ-009 no_port  output  1  high when addr_in_port equals 11.
REQ-010 data_in_port  output  2  data-phase owner (registered), same encoding as addr_in_port.
REQ-011 active_op  output  3  bit n is high when addr_in_port equals n; bits are one-hot or all zero.

Function
REQ-012 The block SHALL hold three registers: owner_q[1:0] (last address-phase owner), rr_ptr[1:0] (last granted port, range 0..2) and data_in_port.
REQ-013 hold SHALL be true when owner_q is not 11, req_sel[owner_q] is 1, and either lock_op[owner_q] is 1 or trans_op of owner_q is BUSY or SEQ.
REQ-014 When HREADYM is 0, addr_in_port SHALL equal owner_q, so the address phase stays stable during wait states.
REQ-015 When HREADYM is 1 and hold is true, addr_in_port SHALL equal owner_q.
REQ-016 When HREADYM is 1 and hold is false with RR_EN=1, addr_in_port SHALL be the first requesting port (req_sel bit 1) searched in the order rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 3); if no port requests, it SHALL be 11.
REQ-017 With RR_EN=0, the search order SHALL be fixed at 0, 1, 2, and rr_ptr SHALL still be updated but SHALL not affect the result.
REQ-018 addr_in_port, no_port and active_op SHALL be combinational from the registers and the inputs, with no input-to-output path other than req_sel, trans_op, lock_op and HREADYM.
REQ-019 On a rising edge with HREADYM=1, owner_q and data_in_port SHALL load addr_in_port, and rr_ptr SHALL load addr_in_port only if addr_in_port is not 11.
REQ-020 On a rising edge with HREADYM=0, owner_q, data_in_port and rr_ptr SHALL hold their values.
REQ-021 Data-phase latency SHALL be exactly one accepted cycle: data_in_port equals the addr_in_port value present at the previous edge where HREADYM was 1.
REQ-022 Locked sequence: while lock_op[owner] stays 1, the port SHALL be retained across IDLE beats, provided req_sel[owner] stays 1.
REQ-023 Lock release: the port SHALL be released at the first arbitration point where lock_op[owner] is 0 and the owner's trans is IDLE or NONSEQ.
REQ-024 If req_sel[owner_q] falls to 0, hold SHALL be false regardless of lock_op, and arbitration proceeds.
REQ-025 Simultaneous requests from all three ports with no hold SHALL give exactly one grant per arbitration point.
REQ-026 Under continuous requests with RR_EN=1, each port SHALL be granted within 3 arbitration points.
REQ-027 An rr_ptr value of 11 SHALL be unreachable; if it occurs, it SHALL be treated as 10.

Reset
REQ-028 While HRESET is 1, owner_q SHALL be 11, data_in_port SHALL be 11 and rr_ptr SHALL be 10, so the first round-robin search starts at port 0.
REQ-029 During reset, outputs SHALL follow the reset register values: addr_in_port equals 11 when HREADYM is 0, and active_op is 000 when no port requests.
REQ-030 Assertion of HRESET mid-burst or mid-lock SHALL abort ownership immediately, asynchronously, without waiting for HREADYM.
REQ-031 After HRESET falls, the first rising edge with HREADYM=1 SHALL perform a normal arbitration.

Verification
REQ-032 Reset then req_sel=111, all trans NONSEQ, HREADYM=1 -> grants 00, 01, 10, 00 on successiv

---
 rtl/ahb_mtx_out_arb.sv | 93 +++++++++
 tb/tb_ahb_mtx_out_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mtx_out_arb.sv
// Output-stage arbiter for a three-port AHB bus matrix: picks the address-phase owner,
// tracks the data-phase owner and drives one-hot per-port active feedback.
module ahb_mtx_out_arb #(
    parameter int unsigned RR_EN = 1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [2:0] req_sel,
    input  logic [5:0] trans_op,
    input  logic [2:0] lock_op,
    input  logic       HREADYM,
    output logic [1:0] addr_in_port,
    output logic       no_port,
    output logic [1:0] data_in_port,
    output logic [2:0] active_op
);

    localparam logic [1:0] NoPort = 2'b11;

    logic [1:0] owner_q;
    logic [1:0] rr_ptr;
    logic [1:0] ptr_eff;
    logic [1:0] first;
    logic [5:0] order;
    logic [1:0] owner_trans;
    logic [3:0] req4;
    logic [3:0] lock4;
    logic       hold;
    logic [1:0] grant;

    // Padded copies so indexing with the "no port" code stays in range.
    assign req4  = {1'b0, req_sel};
    assign lock4 = {1'b0, lock_op};

    always_comb begin
        owner_trans = 2'b00;
        unique case (owner_q)
            2'd0:    owner_trans = trans_op[1:0];
            2'd1:    owner_trans = trans_op[3:2];
            2'd2:    owner_trans = trans_op[5:4];
            default: owner_trans = 2'b00;
        endcase
    end

    // BUSY (01) and SEQ (11) both have the low bit set.
    assign hold = (owner_q != NoPort) && req4[owner_q] && (lock4[owner_q] || owner_trans[0]);

    always_comb begin
        ptr_eff = (rr_ptr == 2'b11) ? 2'b10 : rr_ptr;
        if (RR_EN != 0) begin
            first = (ptr_eff == 2'd2) ? 2'd0 : ptr_eff + 2'd1;
        end else begin
            first = 2'd0;
        end
        unique case (first)
            2'd0:    order = {2'd2, 2'd1, 2'd0};
            2'd1:    order = {2'd0, 2'd2, 2'd1};
            default: order = {2'd1, 2'd0, 2'd2};
        endcase
        // Lowest slot of order has highest priority, so it is applied last.
        grant = NoPort;
        if (req4[order[5:4]]) grant = order[5:4];
        if (req4[order[3:2]]) grant = order[3:2];
        if (req4[order[1:0]]) grant = order[1:0];
    end

    always_comb begin
        if (!HREADYM || hold) begin
            addr_in_port = owner_q;
        end else begin
            addr_in_port = grant;
        end
        no_port      = (addr_in_port == NoPort);
        active_op[0] = (addr_in_port == 2'd0);
        active_op[1] = (addr_in_port == 2'd1);
        active_op[2] = (addr_in_port == 2'd2);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            owner_q      <= NoPort;
            data_in_port <= NoPort;
            rr_ptr       <= 2'b10;
        end else if (HREADYM) begin
            owner_q      <= addr_in_port;
            data_in_port <= addr_in_port;
            if (addr_in_port != NoPort) begin
                rr_ptr <= addr_in_port;
            end
        end
    end

endmodule

// File: tb/tb_ahb_mtx_out_arb.sv
// Bench for ahb_mtx_out_arb: directed scenarios plus a randomized run against a
// behavioural arbitration model, on one round-robin and one fixed-priority instance.
module tb_ahb_mtx_out_arb;

    logic       HCLK;
    logic       HRESET;
    logic [2:0] req_sel;
    logic [5:0] trans_op;
    logic [2:0] lock_op;
    logic       HREADYM;

    logic [1:0] a_rr, d_rr, a_fx, d_fx;
    logic       np_rr, np_fx;
    logic [2:0] act_rr, act_fx;

    int checks = 0;
    int errors = 0;

    // Model state per instance: index 0 round-robin, index 1 fixed priority.
    int m_owner[2];
    int m_ptr[2];
    int m_data[2];

    ahb_mtx_out_arb #(.RR_EN(1)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .req_sel(req_sel), .trans_op(trans_op),
        .lock_op(lock_op), .HREADYM(HREADYM), .addr_in_port(a_rr), .no_port(np_rr),
        .data_in_port(d_rr), .active_op(act_rr)
    );

    ahb_mtx_out_arb #(.RR_EN(0)) dut_fx (
        .HCLK(HCLK), .HRESET(HRESET), .req_sel(req_sel), .trans_op(trans_op),
        .lock_op(lock_op), .HREADYM(HREADYM), .addr_in_port(a_fx), .no_port(np_fx),
        .data_in_port(d_fx), .active_op(act_fx)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 3;
            m_data[k]  = 3;
            m_ptr[k]   = 2;
        end
    endtask

    // Grant rule: keep the owner while stalled or while it holds (lock, BUSY, SEQ),
    // otherwise the first requester after the last grant (or from port 0 if fixed).
    function automatic int exp_grant(int k);
        int o, tr, p;
        o = m_owner[k];
        if (!HREADYM) return o;
        if (o != 3) begin
            tr = int'((trans_op >> (2 * o)) & 6'd3);
            if (req_sel[o] && (lock_op[o] || tr == 1 || tr == 3)) return o;
        end
        for (int i = 1; i <= 3; i++) begin
            p = (k == 0) ? (m_ptr[k] + i) % 3 : i - 1;
            if (req_sel[p]) return p;
        end
        return 3;
    endfunction

    task automatic drive(input logic [2:0] r, input logic [5:0] t, input logic [2:0] l,
                         input logic rdy);
        req_sel  = r;
        trans_op = t;
        lock_op  = l;
        HREADYM  = rdy;
    endtask

    task automatic apply_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        drive(3'b000, 6'b101010, 3'b000, 1'b0);
        @(negedge HCLK);
        HRESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        drive(3'b000, 6'b000000, 3'b000, 1'b0);
        #1;
        checks++; if (a_rr !== 2'd3) begin errors++; $display("FAIL reset_addr got %0d want 3", a_rr); end
        checks++; if (d_rr !== 2'd3) begin errors++; $display("FAIL reset_data got %0d want 3", d_rr); end
        checks++; if (np_rr !== 1'b1) begin errors++; $display("FAIL reset_no_port got %0d want 1", np_rr); end
        checks++; if (act_rr !== 3'b000) begin errors++; $display("FAIL reset_active got %b want 000", act_rr); end
        checks++; if (d_fx !== 2'd3) begin errors++; $display("FAIL reset_data_fx got %0d want 3", d_fx); end
        // Reset pointer of 2 means the first search starts at port 0.
        drive(3'b111, 6'b101010, 3'b000, 1'b1);
        #1;
        checks++; if (a_rr !== 2'd0) begin errors++; $display("FAIL reset_first_search got %0d want 0", a_rr); end
        @(negedge HCLK);
        checks++; if (d_rr !== 2'd3) begin errors++; $display("FAIL reset_hold_data got %0d want 3", d_rr); end
        HRESET = 1'b0;
        model_reset();
    endtask

    task automatic test_rr_sequence();
        logic [1:0] e, prev;
        apply_reset();
        drive(3'b111, 6'b101010, 3'b000, 1'b1);
        prev = 2'd3;
        for (int i = 0; i < 5; i++) begin
            e = 2'(i % 3);
            #1;
            checks++; if (a_rr !== e) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, a_rr, e); end
            checks++; if (d_rr !== prev) begin errors++; $display("FAIL rr_data_lag[%0d] got %0d want %0d", i, d_rr, prev); end
            checks++; if (a_fx !== 2'd0) begin errors++; $display("FAIL fx_grant[%0d] got %0d want 0", i, a_fx); end
            prev = e;
            @(negedge HCLK);
        end
    endtask

    task automatic test_seq_hold();
        apply_reset();
        drive(3'b111, 6'b101010, 3'b000, 1'b1);
        #1;
        checks++; if (a_rr !== 2'd0) begin errors++; $display("FAIL seq_setup0 got %0d want 0", a_rr); end
        @(negedge HCLK);
        #1;
        checks++; if (a_rr !== 2'd1) begin errors++; $display("FAIL seq_setup1 got %0d want 1", a_rr); end
        @(negedge HCLK);
        trans_op = 6'b101110;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_rr !== 2'd1) begin errors++; $display("FAIL seq_hold[%0d] got %0d want 1", i, a_rr); end
            @(negedge HCLK);
        end
        trans_op = 6'b101010;
        #1;
        checks++; if (a_rr !== 2'd2) begin errors++; $display("FAIL seq_release got %0d want 2", a_rr); end
        checks++; if (d_rr !== 2'd1) begin errors++; $display("FAIL seq_release_data got %0d want 1", d_rr); end
        @(negedge HCLK);
    endtask

    task automatic test_wait_states();
        apply_reset();
        drive(3'b001, 6'b101010, 3'b000, 1'b1);
        #1;
        checks++; if (a_rr !== 2'd0) begin errors++; $display("FAIL wait_setup got %0d want 0", a_rr); end
        @(negedge HCLK);
        drive(3'b101, 6'b101010, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_rr !== 2'd0) begin errors++; $display("FAIL wait_addr[%0d] got %0d want 0", i, a_rr); end
            checks++; if (d_rr !== 2'd0) begin errors++; $display("FAIL wait_data[%0d] got %0d want 0", i, d_rr); end
            checks++; if (act_rr !== 3'b001) begin errors++; $display("FAIL wait_active[%0d] got %b want 001", i, act_rr); end
            @(negedge HCLK);
        end
        HREADYM = 1'b1;
        #1;
        checks++; if (a_rr !== 2'd2) begin errors++; $display("FAIL wait_regrant got %0d want 2", a_rr); end
        checks++; if (act_rr !== 3'b100) begin errors++; $display("FAIL wait_regrant_active got %b want 100", act_rr); end
        @(negedge HCLK);
        checks++; if (d_rr !== 2'd2) begin errors++; $display("FAIL wait_regrant_data got %0d want 2", d_rr); end
    endtask

    task automatic test_lock();
        apply_reset();
        drive(3'b011, 6'b101010, 3'b001, 1'b1);
        #1;
        checks++; if (a_rr !== 2'd0) begin errors++; $display("FAIL lock_setup got %0d want 0", a_rr); end
        @(negedge HCLK);
        trans_op = 6'b101000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_rr !== 2'd0) begin errors++; $display("FAIL lock_retain[%0d] got %0d want 0", i, a_rr); end
            @(negedge HCLK);
        end
        lock_op = 3'b000;
        #1;
        checks++; if (a_rr !== 2'd1) begin errors++; $display("FAIL lock_release got %0d want 1", a_rr); end
        // Dropping the owner's select breaks a lock.
        apply_reset();
        drive(3'b011, 6'b101010, 3'b001, 1'b1);
        @(negedge HCLK);
        req_sel = 3'b010;
        #1;
        checks++; if (a_rr !== 2'd1) begin errors++; $display("FAIL lock_desel got %0d want 1", a_rr); end
        @(negedge HCLK);
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        drive(3'b110, 6'b101010, 3'b000, 1'b1);
        #1;
        checks++; if (a_fx !== 2'd1) begin errors++; $display("FAIL fixed_first got %0d want 1", a_fx); end
        @(negedge HCLK);
        req_sel = 3'b111;
        #1;
        checks++; if (a_fx !== 2'd0) begin errors++; $display("FAIL fixed_prio got %0d want 0", a_fx); end
        checks++; if (a_rr !== 2'd2) begin errors++; $display("FAIL fixed_vs_rr got %0d want 2", a_rr); end
        @(negedge HCLK);
    endtask

    task automatic test_reset_abort();
        apply_reset();
        drive(3'b100, 6'b101010, 3'b000, 1'b1);
        #1;
        checks++; if (a_rr !== 2'd2) begin errors++; $display("FAIL abort_setup got %0d want 2", a_rr); end
        @(negedge HCLK);
        trans_op = 6'b111010;
        #1;
        checks++; if (a_rr !== 2'd2) begin errors++; $display("FAIL abort_seq got %0d want 2", a_rr); end
        #2;
        HRESET = 1'b1;
        drive(3'b000, 6'b111010, 3'b000, 1'b0);
        #1;
        checks++; if (a_rr !== 2'd3) begin errors++; $display("FAIL abort_owner got %0d want 3", a_rr); end
        checks++; if (d_rr !== 2'd3) begin errors++; $display("FAIL abort_data got %0d want 3", d_rr); end
        checks++; if (act_rr !== 3'b000) begin errors++; $display("FAIL abort_active got %b want 000", act_rr); end
        checks++; if (np_rr !== 1'b1) begin errors++; $display("FAIL abort_no_port got %0d want 1", np_rr); end
        @(negedge HCLK);
        HRESET = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int g;
        logic [1:0] a, d;
        logic       np;
        logic [2:0] act, ea;
        apply_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom % 64 == 0) begin
                HRESET = 1'b1;
                @(negedge HCLK);
                HRESET = 1'b0;
                model_reset();
            end
            req_sel  = 3'($urandom);
            trans_op = 6'($urandom);
            lock_op  = ($urandom % 4 == 0) ? 3'($urandom) : 3'b000;
            HREADYM  = ($urandom % 4 != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                g   = exp_grant(k);
                a   = (k == 0) ? a_rr : a_fx;
                d   = (k == 0) ? d_rr : d_fx;
                np  = (k == 0) ? np_rr : np_fx;
                act = (k == 0) ? act_rr : act_fx;
                ea  = (g == 3) ? 3'b000 : 3'(1 << g);
                checks++; if (a !== 2'(g)) begin errors++; $display("FAIL rand_addr k%0d n%0d got %0d want %0d", k, n, a, g); end
                checks++; if (d !== 2'(m_data[k])) begin errors++; $display("FAIL rand_data k%0d n%0d got %0d want %0d", k, n, d, m_data[k]); end
                checks++; if (np !== (g == 3)) begin errors++; $display("FAIL rand_no_port k%0d n%0d got %0d want %0d", k, n, np, g == 3); end
                checks++; if (act !== ea) begin errors++; $display("FAIL rand_active k%0d n%0d got %b want %b", k, n, act, ea); end
                if (HREADYM) begin
                    m_owner[k] = g;
                    m_data[k]  = g;
                    if (g != 3) m_ptr[k] = g;
                end
            end
            @(negedge HCLK);
        end
    endtask

    initial begin
        HRESET = 1'b1;
        drive(3'b000, 6'b000000, 3'b000, 1'b0);
        model_reset();
        test_reset();
        test_rr_sequence();
        test_seq_hold();
        test_wait_states();
        test_lock();
        test_fixed_prio();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
